// File: rtl/spi_timing_gen.sv
// SPI master timing engine: one start request becomes a full CS/SCK frame with datapath strobes.
// Optional CS setup/hold guard states are built when SPI_CS_GUARD_EN is defined.
module spi_timing_gen #(
  parameter int unsigned MAX_WIDTH_LOG = 5,
  parameter int unsigned DIV_W         = 8,
  parameter int unsigned CS_NUM        = 4,
  parameter int unsigned GUARD_CYCLES  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       spi_start,
  input  logic                       cpol,
  input  logic                       cpha,
  input  logic [MAX_WIDTH_LOG:0]     spi_width,
  input  logic [DIV_W-1:0]           clk_div,
  input  logic [$clog2(CS_NUM)-1:0]  cs_sel,
  output logic                       sck,
  output logic [CS_NUM-1:0]          cs_n,
  output logic                       load,
  output logic                       shift_edge,
  output logic                       sample_edge,
  output logic [MAX_WIDTH_LOG:0]     bit_cnt,
  output logic                       busy,
  output logic                       spi_finish
);

  localparam int unsigned WW = MAX_WIDTH_LOG + 1;
  localparam int unsigned EW = MAX_WIDTH_LOG + 2;
  localparam int unsigned SW = $clog2(CS_NUM);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_HOLD} state_t;

  state_t            state, state_nxt;
  logic              cpol_q, cpha_q;
  logic [WW-1:0]     width_q;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  hp_cnt, hp_cnt_d;
  logic [EW-1:0]     edge_cnt, edge_cnt_d;
  logic              sck_d, load_d, shift_d, sample_d, busy_d, finish_d;
  logic [CS_NUM-1:0] cs_n_d;
  logic [WW-1:0]     bit_cnt_d;

  logic              accept_c, wrap_c, edges_done_c, leading_c;
  logic [EW-1:0]     two_w_c, edge_nxt_c;

`ifdef SPI_CS_GUARD_EN
  localparam int unsigned GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  logic [GW-1:0] g_cnt, g_cnt_d;
  logic          g_last_c;
  assign g_last_c = (g_cnt == GW'(GUARD_CYCLES - 1));
`endif

  // Requests with an illegal width or slave index are silently dropped
  assign accept_c = (state == S_IDLE) && !busy && spi_start
                    && (spi_width != '0)
                    && (32'(spi_width) <= (32'd1 << MAX_WIDTH_LOG))
                    && (32'(cs_sel) < CS_NUM);

  assign two_w_c      = {width_q, 1'b0};
  assign wrap_c       = (hp_cnt == div_q);
  assign edges_done_c = (edge_cnt == two_w_c);
  assign edge_nxt_c   = edge_cnt + EW'(1);
  assign leading_c    = ~edge_cnt[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept_c) begin
`ifdef SPI_CS_GUARD_EN
        state_nxt = S_SETUP;
`else
        state_nxt = S_RUN;
`endif
      end
`ifdef SPI_CS_GUARD_EN
      S_SETUP: if (g_last_c) state_nxt = S_RUN;
      S_HOLD:  if (g_last_c) state_nxt = S_IDLE;
`endif
      S_RUN: if (wrap_c && edges_done_c) begin
`ifdef SPI_CS_GUARD_EN
        state_nxt = S_HOLD;
`else
        state_nxt = S_IDLE;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values for every registered output and counter
  always_comb begin
    sck_d      = sck;
    cs_n_d     = cs_n;
    load_d     = 1'b0;
    shift_d    = 1'b0;
    sample_d   = 1'b0;
    finish_d   = 1'b0;
    busy_d     = busy;
    bit_cnt_d  = bit_cnt;
    hp_cnt_d   = hp_cnt;
    edge_cnt_d = edge_cnt;
`ifdef SPI_CS_GUARD_EN
    g_cnt_d    = g_cnt;
`endif
    case (state)
      S_IDLE: begin
        sck_d = cpol;
        if (accept_c) begin
          cs_n_d     = ~(CS_NUM'(1) << cs_sel);
          busy_d     = 1'b1;
          load_d     = 1'b1;
          bit_cnt_d  = '0;
          hp_cnt_d   = '0;
          edge_cnt_d = '0;
`ifdef SPI_CS_GUARD_EN
          g_cnt_d    = '0;
`endif
        end
      end
`ifdef SPI_CS_GUARD_EN
      S_SETUP: begin
        sck_d   = cpol_q;
        g_cnt_d = g_last_c ? '0 : g_cnt + GW'(1);
      end
      S_HOLD: begin
        g_cnt_d = g_cnt + GW'(1);
        if (g_last_c) begin
          cs_n_d   = '1;
          busy_d   = 1'b0;
          finish_d = 1'b1;
        end
      end
`endif
      S_RUN: begin
        if (!wrap_c) begin
          hp_cnt_d = hp_cnt + DIV_W'(1);
        end else begin
          hp_cnt_d = '0;
          if (edges_done_c) begin
            // Final idle half-period elapsed
            sck_d = cpol_q;
`ifdef SPI_CS_GUARD_EN
            g_cnt_d  = '0;
`else
            cs_n_d   = '1;
            busy_d   = 1'b0;
            finish_d = 1'b1;
`endif
          end else begin
            sck_d      = ~sck;
            edge_cnt_d = edge_nxt_c;
            if (leading_c != cpha_q) begin
              sample_d  = 1'b1;
              bit_cnt_d = bit_cnt + WW'(1);
            end else if (cpha_q || (edge_nxt_c != two_w_c)) begin
              shift_d = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck         <= 1'b0;
      cs_n        <= '1;
      load        <= 1'b0;
      shift_edge  <= 1'b0;
      sample_edge <= 1'b0;
      spi_finish  <= 1'b0;
      busy        <= 1'b0;
      bit_cnt     <= '0;
      hp_cnt      <= '0;
      edge_cnt    <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      width_q     <= '0;
      div_q       <= '0;
`ifdef SPI_CS_GUARD_EN
      g_cnt       <= '0;
`endif
    end else begin
      sck         <= sck_d;
      cs_n        <= cs_n_d;
      load        <= load_d;
      shift_edge  <= shift_d;
      sample_edge <= sample_d;
      spi_finish  <= finish_d;
      busy        <= busy_d;
      bit_cnt     <= bit_cnt_d;
      hp_cnt      <= hp_cnt_d;
      edge_cnt    <= edge_cnt_d;
`ifdef SPI_CS_GUARD_EN
      g_cnt       <= g_cnt_d;
`endif
      if (accept_c) begin
        cpol_q  <= cpol;
        cpha_q  <= cpha;
        width_q <= spi_width;
        div_q   <= clk_div;
      end
    end
  end

endmodule
